// File: rtl/core_mem_pkg.sv
// Shared definitions for the data-memory responder slice.
//   - Access size encodings carried on REQ_SIZE.
//   - One-hot FSM state type for the responder.
//   - byte_en:      byte-enable mask for a store of a given size at a given lane.
//   - load_extract: lane extraction plus sign/zero extension of a loaded word.
package core_mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    ACCESS = 3'b010,
    RESP   = 3'b100
  } state_e;

  // Misaligned halves never reach the RAM (the error check gates them),
  // so only lanes 0 and 2 matter for SZ_H.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    return 4'b0001 << lane;
      SZ_H:    return lane[1] ? 4'b1100 : 4'b0011;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    return is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_H:    return is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/core_dmem_ram.sv
// Single-port synchronous word RAM with per-byte write enables.
//   CLK    : clock, write and read both take effect on the rising edge
//   be     : byte write enables, bit k writes wdata[8k+7:8k]
//   re     : read enable, rdata is registered one cycle after re
//   addr   : word index
//   wdata  : write data
//   rdata  : registered read data (holds when re is low)
module core_dmem_ram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          CLK,
  input  logic [3:0]    be,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: the array and its read register have no reset so the tools can map
  // them onto RAM macros; their contents are undefined until written.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < 4; k++) begin
      if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/core_dmem_responder.sv
// Load/store responder for the core's data port. Takes one request at a time,
// performs it on a byte-enabled synchronous RAM and returns a one-cycle
// response pulse two cycles after acceptance.
//   CLK, RST_N        : clock, asynchronous active-low reset
//   REQ_VALID/READY   : request handshake, accepted on VALID & READY
//   REQ_ADDR          : byte address
//   REQ_WDATA         : lane-replicated store data
//   REQ_WE            : 1 = store, 0 = load
//   REQ_SIZE          : byte / half / word (11 is illegal)
//   REQ_UNSIGNED      : zero-extend loads when set
//   RSP_VALID         : one-cycle response pulse
//   RSP_RDATA         : extended load data, 0 for stores and errors
//   RSP_ERR           : request rejected, memory untouched
module core_dmem_responder
  import core_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  input  logic        REQ_WE,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_UNSIGNED,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic        we_q, uns_q;
  logic [1:0]  size_q;

  logic [31:0] offset;
  logic        err;
  logic [3:0]  ram_be;
  logic        ram_re;
  logic [31:0] ram_rdata;

  // Unsigned wrap-around makes addresses below BASE_ADDR land out of range too.
  assign offset = addr_q - BASE_ADDR;
  assign err    = (size_q == 2'b11)
               || (size_q == SZ_H && addr_q[0])
               || (size_q == SZ_W && addr_q[1:0] != 2'b00)
               || (offset >= SPAN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_W;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (REQ_VALID && REQ_READY) begin
        addr_q  <= REQ_ADDR;
        wdata_q <= REQ_WDATA;
        we_q    <= REQ_WE;
        size_q  <= REQ_SIZE;
        uns_q   <= REQ_UNSIGNED;
      end
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    REQ_READY = 1'b0;
    RSP_VALID = 1'b0;
    RSP_RDATA = '0;
    RSP_ERR   = 1'b0;
    ram_be    = 4'b0000;
    ram_re    = 1'b0;
    case (state_q)
      IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) state_d = ACCESS;
      end
      ACCESS: begin
        state_d = RESP;
        if (!err) begin
          if (we_q) ram_be = byte_en(size_q, addr_q[1:0]);
          else      ram_re = 1'b1;
        end
      end
      RESP: begin
        state_d   = IDLE;
        RSP_VALID = 1'b1;
        RSP_ERR   = err;
        if (!err && !we_q) RSP_RDATA = load_extract(ram_rdata, size_q, addr_q[1:0], uns_q);
      end
      default: state_d = IDLE;
    endcase
  end

  core_dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .CLK  (CLK),
    .be   (ram_be),
    .re   (ram_re),
    .addr (offset[AW+1:2]),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_core_dmem_responder.sv
// Scoreboard bench for core_dmem_responder: each accepted request pushes its
// expected response; a monitor pops and compares on every RSP_VALID pulse,
// including the accept-to-response latency.
module tb_core_dmem_responder;
  import core_mem_pkg::*;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        CLK, RST_N;
  logic        REQ_VALID, REQ_READY;
  logic [31:0] REQ_ADDR, REQ_WDATA;
  logic        REQ_WE;
  logic [1:0]  REQ_SIZE;
  logic        REQ_UNSIGNED;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;

  core_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_WE(REQ_WE),
    .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned last_acc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Response monitor, sampling on the falling edge.
  always @(negedge CLK) begin
    if (RSP_VALID === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_rsp", {31'b0, RSP_VALID}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_rdata"}, RSP_RDATA, e.rdata);
        check({e.tag, "_err"}, {31'b0, RSP_ERR}, {31'b0, e.err});
        check({e.tag, "_latency"}, cyc - e.acc, 32'd2);
      end
    end
  end

  // Drives one request, waits (bounded) for acceptance, records the expected
  // response, then scrambles the request inputs to prove they were latched.
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int waited = 0;
    REQ_VALID    = 1'b1;
    REQ_WE       = we;
    REQ_SIZE     = size;
    REQ_UNSIGNED = uns;
    REQ_ADDR     = addr;
    REQ_WDATA    = wdata;
    while (REQ_READY !== 1'b1 && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    if (REQ_READY !== 1'b1) begin
      check({tag, "_ready_timeout"}, {31'b0, REQ_READY}, 32'd1);
    end else begin
      last_acc = cyc;
      sb.push_back('{tag, exp_rd, exp_err, cyc});
      @(posedge CLK);
      #1;
      REQ_ADDR     = $urandom;
      REQ_WDATA    = $urandom;
      REQ_WE       = ~we;
      REQ_SIZE     = 2'($urandom);
      REQ_UNSIGNED = ~uns;
    end
  endtask

  task automatic drain(input string tag);
    int waited = 0;
    while (sb.size() != 0 && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic single(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input string tag);
    send(we, size, uns, addr, wdata, exp_rd, exp_err, tag);
    REQ_VALID = 1'b0;
    drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0;
    REQ_VALID = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
    REQ_WE = 1'b0; REQ_SIZE = SZ_W; REQ_UNSIGNED = 1'b0;

    // Reset state.
    repeat (3) @(negedge CLK);
    check("in_reset_rsp_valid", {31'b0, RSP_VALID}, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    check("rst_ready", {31'b0, REQ_READY}, 32'd1);
    check("rst_rdata", RSP_RDATA, 32'd0);
    check("rst_err", {31'b0, RSP_ERR}, 32'd0);

    // Reset during ACCESS of a store: response must be dropped.
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_SIZE = SZ_W; REQ_UNSIGNED = 1'b0;
    REQ_ADDR = 32'h10; REQ_WDATA = 32'hDEAD_BEEF;
    @(posedge CLK);
    #2;
    check("mid_access_ready", {31'b0, REQ_READY}, 32'd0);
    RST_N = 1'b0;
    REQ_VALID = 1'b0;
    #1;
    check("async_rst_ready", {31'b0, REQ_READY}, 32'd1);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("post_rst_ready", {31'b0, REQ_READY}, 32'd1);
    check("post_rst_valid", {31'b0, RSP_VALID}, 32'd0);
    check("post_rst_rdata", RSP_RDATA, 32'd0);

    // Word store / load.
    single(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, "sw_10");
    single(1'b0, SZ_W, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, "lw_10_a");

    // Byte merge and byte loads.
    single(1'b1, SZ_B, 1'b0, 32'h11, 32'h5A5A_5A5A, 32'h0, 1'b0, "sb_11");
    single(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEAD_5AEF, 1'b0, "lw_10_b");
    single(1'b0, SZ_B, 1'b0, 32'h11, 32'h0, 32'h0000_005A, 1'b0, "lb_11");
    single(1'b0, SZ_B, 1'b0, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0, "lb_13");
    single(1'b0, SZ_B, 1'b1, 32'h13, 32'h0, 32'h0000_00DE, 1'b0, "lbu_13");

    // Half store and loads.
    single(1'b1, SZ_H, 1'b0, 32'h12, 32'h8001_8001, 32'h0, 1'b0, "sh_12");
    single(1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 32'hFFFF_8001, 1'b0, "lh_12");
    single(1'b0, SZ_H, 1'b1, 32'h12, 32'h0, 32'h0000_8001, 1'b0, "lhu_12");
    single(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h8001_5AEF, 1'b0, "lw_10_c");

    // Errors.
    single(1'b0, SZ_H,  1'b0, 32'h13, 32'h0, 32'h0, 1'b1, "lh_13_misalign");
    single(1'b1, SZ_W,  1'b0, 32'h12, 32'hFFFF_FFFF, 32'h0, 1'b1, "sw_12_misalign");
    single(1'b0, SZ_W,  1'b0, 32'h10, 32'h0, 32'h8001_5AEF, 1'b0, "lw_10_unchanged");
    single(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, "size11");
    single(1'b0, SZ_W,  1'b0, BASE + 32'(DEPTH * 4), 32'h0, 32'h0, 1'b1, "lw_out_of_range");

    // Last word in range.
    single(1'b1, SZ_W, 1'b0, BASE + 32'(DEPTH * 4 - 4), 32'hA5A5_0F0F, 32'h0, 1'b0, "sw_top");
    single(1'b0, SZ_W, 1'b0, BASE + 32'(DEPTH * 4 - 4), 32'h0, 32'hA5A5_0F0F, 1'b0, "lw_top");

    // Back-to-back with VALID held: accepts every 3 cycles, store then load
    // to the same word sees the new data.
    begin
      int unsigned prev;
      send(1'b1, SZ_W, 1'b0, 32'h20, 32'h1122_3344, 32'h0, 1'b0, "b2b_sw");
      check("b2b0_ready_low", {31'b0, REQ_READY}, 32'd0);
      prev = last_acc;
      send(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'h1122_3344, 1'b0, "b2b_lw");
      check("b2b1_gap", last_acc - prev, 32'd3);
      prev = last_acc;
      send(1'b0, SZ_B, 1'b0, 32'h23, 32'h0, 32'h0000_0011, 1'b0, "b2b_lb");
      check("b2b2_gap", last_acc - prev, 32'd3);
      prev = last_acc;
      send(1'b0, SZ_H, 1'b1, 32'h20, 32'h0, 32'h0000_3344, 1'b0, "b2b_lhu");
      check("b2b3_gap", last_acc - prev, 32'd3);
      REQ_VALID = 1'b0;
      drain("b2b");
    end

    repeat (4) @(negedge CLK);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
